// File: rtl/noc_outport_tx_if.sv
// noc_outport_tx_if: local flit handshake plus BiNoC link signals of one router output port
//   master: local controller / link environment (drives PacketIn, reqOutCtr, dirGnt, linkFull)
//   slave : the transmitter (drives gntOutCtr, txFull, txEmpty, dirReq, linkOut, linkValid, protoErr)
interface noc_outport_tx_if #(parameter int dataWidth = 32);
  logic [dataWidth-1:0] PacketIn, linkOut;
  logic reqOutCtr, gntOutCtr, txFull, txEmpty, dirReq, dirGnt, linkValid, linkFull, protoErr;
  modport master(
    output PacketIn, reqOutCtr, dirGnt, linkFull,
    input gntOutCtr, txFull, txEmpty, dirReq, linkOut, linkValid, protoErr
  );
  modport slave(
    input PacketIn, reqOutCtr, dirGnt, linkFull,
    output gntOutCtr, txFull, txEmpty, dirReq, linkOut, linkValid, protoErr
  );
endinterface

// File: rtl/noc_outport_tx.sv
// noc_outport_tx: buffers local flits and streams whole packets onto a negotiated bidirectional link
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of noc_outport_tx_if (local req/gnt, buffer status, dirReq/dirGnt, link data, protoErr)
module noc_outport_tx #(
  parameter int dataWidth = 32,
  parameter int addressWidth = 2,
  parameter int dim = 2
) (
  input logic clk,
  input logic rst,
  noc_outport_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SEND, RELEASE} state_t;
  localparam int Depth = 2 ** addressWidth;
  state_t r_state, w_next;
  logic [dataWidth-1:0] r_mem [Depth];
  logic [addressWidth:0] r_wptr, r_rptr;
  logic r_gnt, r_err;
  logic w_full, w_empty, w_push, w_valid, w_xfer;
  logic [dataWidth-1:0] w_head;
  logic [1:0] w_type;
  // the x/y header fields are only carried, but they must fit beside the type bits
  if (4 * dim > dataWidth - 2) begin : g_dim_chk
    $error("noc_outport_tx: header coordinates do not fit in the flit");
  end
  assign w_full = (r_wptr[addressWidth-1:0] == r_rptr[addressWidth-1:0]) && (r_wptr[addressWidth] != r_rptr[addressWidth]);
  assign w_empty = r_wptr == r_rptr;
  assign w_push = bus.reqOutCtr && !w_full && !rst;
  assign w_head = r_mem[r_rptr[addressWidth-1:0]];
  assign w_type = w_head[dataWidth-1 -: 2];
  // link is driven only while we own it and have data; a lost grant or underrun idles it
  assign w_valid = !rst && r_state == SEND && bus.dirGnt && !w_empty;
  assign w_xfer = w_valid && !bus.linkFull;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr[addressWidth-1:0]] <= bus.PacketIn;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_wptr <= '0;
      r_rptr <= '0;
      r_gnt <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wptr <= r_wptr + (addressWidth + 1)'(w_push);
      r_rptr <= r_rptr + (addressWidth + 1)'(w_xfer);
      r_gnt <= w_push;
      r_err <= r_err | (r_state == SEND && !bus.dirGnt);
    end
  // type bit 1 marks head/single (packet start), bit 0 marks tail/single (packet end)
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? ((!w_empty && w_type[1]) ? REQ : IDLE) :
             r_state == REQ  ? (bus.dirGnt ? SEND : REQ) :
             r_state == SEND ? ((w_xfer && w_type[0]) ? RELEASE : SEND) : IDLE;
  end
  assign bus.gntOutCtr = r_gnt;
  assign bus.txFull = w_full;
  assign bus.txEmpty = w_empty;
  assign bus.dirReq = r_state == REQ || r_state == SEND;
  assign bus.linkValid = w_valid;
  assign bus.linkOut = w_valid ? w_head : '0;
  assign bus.protoErr = r_err;
endmodule

// File: tb/tb_noc_outport_tx.sv
// tb_noc_outport_tx: randomized and directed check of noc_outport_tx against a queue-based packet model
module tb_noc_outport_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  noc_outport_tx_if #(.dataWidth(32)) bus();
  noc_outport_tx #(.dataWidth(32), .addressWidth(2), .dim(2)) dut(.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int gnt_cnt = 0;
  logic [31:0] m_q[$];
  int m_ph;
  logic m_gnt, m_err;
  logic [31:0] xf[$];
  int xf_cyc[$];
  logic req_hist[int];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask
  function automatic logic e_valid();
    return m_ph == 2 && bus.dirGnt && m_q.size() > 0;
  endfunction
  always @(posedge clk) cyc++;
  // model phases: 0 idle, 1 requesting, 2 owning the link, 3 release gap
  always @(posedge clk or posedge rst) begin : mdl
    logic push, xfer, tl;
    int nph;
    if (rst) begin
      m_q.delete();
      m_ph = 0;
      m_gnt = 0;
      m_err = 0;
    end else begin
      push = bus.reqOutCtr && m_q.size() < 4;
      xfer = e_valid() && !bus.linkFull;
      tl = m_q.size() > 0 && m_q[0][30];
      nph = m_ph == 0 ? ((m_q.size() > 0 && m_q[0][31]) ? 1 : 0) :
            m_ph == 1 ? (bus.dirGnt ? 2 : 1) :
            m_ph == 2 ? ((xfer && tl) ? 3 : 2) : 0;
      if (m_ph == 2 && !bus.dirGnt) m_err = 1;
      if (xfer) void'(m_q.pop_front());
      if (push) m_q.push_back(bus.PacketIn);
      m_gnt = push;
      m_ph = nph;
    end
  end
  always @(negedge clk) begin : cmp
    logic v;
    if (!rst) begin
      v = e_valid();
      chk("txEmpty", bus.txEmpty, m_q.size() == 0);
      chk("txFull", bus.txFull, m_q.size() == 4);
      chk("gntOutCtr", bus.gntOutCtr, m_gnt);
      chk("dirReq", bus.dirReq, m_ph == 1 || m_ph == 2);
      chk("linkValid", bus.linkValid, v);
      chk("linkOut", bus.linkOut, v ? m_q[0] : 32'h0);
      chk("protoErr", bus.protoErr, m_err);
      req_hist[cyc] = bus.dirReq;
      if (bus.gntOutCtr) gnt_cnt++;
      if (bus.linkValid && !bus.linkFull) begin
        xf.push_back(bus.linkOut);
        xf_cyc.push_back(cyc);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_xf(int n, int budget, string nm);
    int b = 0;
    while (xf.size() < n && b < budget) begin
      tick();
      b++;
    end
    n_chk++;
    if (xf.size() >= n) n_pass++;
    else $display("FAIL %s: timeout with %0d transfers, required %0d", nm, xf.size(), n);
  endtask
  task automatic push3(logic [31:0] a, logic [31:0] b, logic [31:0] c);
    bus.reqOutCtr = 1;
    bus.PacketIn = a;
    tick();
    bus.PacketIn = b;
    tick();
    bus.PacketIn = c;
    tick();
    bus.reqOutCtr = 0;
  endtask
  task automatic drain(int budget);
    int b = 0;
    while (!(bus.txEmpty && !bus.dirReq) && b < budget) begin
      tick();
      b++;
    end
    tick();
    tick();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int g0, k0, b, i;
    logic [31:0] d[8];
    logic [31:0] e;
    bus.PacketIn = 0;
    bus.reqOutCtr = 0;
    bus.dirGnt = 0;
    bus.linkFull = 0;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    tick();
    // single packet, grant one cycle after dirReq
    g0 = gnt_cnt;
    push3(32'h8000_0012, 32'h0000_0AAA, 32'h4000_0BBB);
    b = 0;
    while (!bus.dirReq && b < 10) begin
      tick();
      b++;
    end
    chk("dirReq_raised", bus.dirReq, 1);
    tick();
    bus.dirGnt = 1;
    wait_xf(3, 20, "single_pkt");
    tick();
    tick();
    chk("sp_flit0", xf[0], 32'h8000_0012);
    chk("sp_flit1", xf[1], 32'h0000_0AAA);
    chk("sp_flit2", xf[2], 32'h4000_0BBB);
    chk("sp_consec01", xf_cyc[1] - xf_cyc[0], 1);
    chk("sp_consec12", xf_cyc[2] - xf_cyc[1], 1);
    chk("sp_gnt_pulses", gnt_cnt - g0, 3);
    chk("sp_dirReq_drop", req_hist[xf_cyc[2] + 1], 0);
    drain(20);
    // back-pressure on the body
    k0 = xf.size();
    push3(32'h8000_0021, 32'h0000_0AAA, 32'h4000_0BBC);
    b = 0;
    while (!(bus.linkValid && bus.linkOut == 32'h0000_0AAA) && b < 20) begin
      tick();
      b++;
    end
    bus.linkFull = 1;
    repeat (3) begin
      tick();
      chk("bp_hold_data", bus.linkOut, 32'h0000_0AAA);
      chk("bp_hold_valid", bus.linkValid, 1);
    end
    bus.linkFull = 0;
    wait_xf(k0 + 3, 20, "bp_drain");
    chk("bp_order1", xf[k0 + 1], 32'h0000_0AAA);
    chk("bp_order2", xf[k0 + 2], 32'h4000_0BBC);
    chk("bp_delay", xf_cyc[k0 + 1] - xf_cyc[k0], 4);
    drain(20);
    // fill with no grant, then drain while pushing eight more to wrap the pointers
    bus.dirGnt = 0;
    k0 = xf.size();
    bus.reqOutCtr = 1;
    for (int j = 0; j < 5; j++) begin
      bus.PacketIn = j == 0 ? 32'h8000_0100 : 32'h0000_0100 + j;
      tick();
    end
    bus.reqOutCtr = 0;
    chk("full_after4", bus.txFull, 1);
    chk("fifth_not_granted", bus.gntOutCtr, 0);
    bus.dirGnt = 1;
    for (int j = 0; j < 8; j++) d[j] = j == 7 ? 32'h4000_010B : 32'h0000_0104 + j;
    i = 0;
    b = 0;
    while (i < 8 && b < 100) begin
      bus.PacketIn = d[i];
      bus.reqOutCtr = 1;
      tick();
      if (bus.gntOutCtr) i++;
      b++;
    end
    bus.reqOutCtr = 0;
    chk("wrap_pushes", i, 8);
    wait_xf(k0 + 12, 100, "wrap_drain");
    for (int j = 0; j < 12; j++) begin
      e = j == 11 ? 32'h4000_010B : j == 0 ? 32'h8000_0100 : 32'h0000_0100 + j;
      chk("wrap_order", xf[k0 + j], e);
    end
    drain(20);
    chk("wrap_empty", bus.txEmpty, 1);
    // two single-flit packets back to back
    k0 = xf.size();
    bus.reqOutCtr = 1;
    bus.PacketIn = 32'hC000_0001;
    tick();
    bus.PacketIn = 32'hC000_0002;
    tick();
    bus.reqOutCtr = 0;
    wait_xf(k0 + 2, 50, "b2b");
    chk("b2b_first", xf[k0], 32'hC000_0001);
    chk("b2b_second", xf[k0 + 1], 32'hC000_0002);
    chk("b2b_gap", xf_cyc[k0 + 1] - xf_cyc[k0] >= 3, 1);
    chk("b2b_release", req_hist[xf_cyc[k0] + 1], 0);
    drain(20);
    // grant lost after the head
    k0 = xf.size();
    push3(32'h8000_0055, 32'h0000_0066, 32'h4000_0077);
    b = 0;
    while (xf.size() <= k0 && b < 20) begin
      tick();
      b++;
    end
    bus.dirGnt = 0;
    #1;
    chk("pe_valid_drop", bus.linkValid, 0);
    chk("pe_out_zero", bus.linkOut, 0);
    tick();
    chk("pe_err_set", bus.protoErr, 1);
    tick();
    tick();
    bus.dirGnt = 1;
    wait_xf(k0 + 3, 20, "pe_resume");
    chk("pe_body", xf[k0 + 1], 32'h0000_0066);
    chk("pe_tail", xf[k0 + 2], 32'h4000_0077);
    chk("pe_sticky", bus.protoErr, 1);
    drain(20);
    // randomized traffic
    for (int j = 0; j < 1500; j++) begin
      bus.reqOutCtr = $urandom_range(1, 0);
      bus.PacketIn = {2'($urandom_range(3, 0)), 30'($urandom)};
      bus.dirGnt = $urandom_range(9, 0) < 8;
      bus.linkFull = $urandom_range(3, 0) == 0;
      tick();
    end
    bus.reqOutCtr = 0;
    bus.dirGnt = 1;
    bus.linkFull = 0;
    repeat (20) tick();
    // asynchronous reset in the middle of a packet
    rst = 1;
    tick();
    rst = 0;
    tick();
    k0 = xf.size();
    push3(32'h8000_0031, 32'h0000_0032, 32'h0000_0033);
    b = 0;
    while (xf.size() <= k0 && b < 20) begin
      tick();
      b++;
    end
    chk("pre_rst_valid", bus.linkValid, 1);
    chk("pre_rst_data", bus.linkOut, 32'h0000_0032);
    rst = 1;
    #1;
    chk("rst_valid", bus.linkValid, 0);
    chk("rst_out", bus.linkOut, 0);
    chk("rst_dirReq", bus.dirReq, 0);
    tick();
    tick();
    rst = 0;
    tick();
    chk("post_rst_empty", bus.txEmpty, 1);
    chk("post_rst_gnt", bus.gntOutCtr, 0);
    chk("post_rst_dirReq", bus.dirReq, 0);
    chk("post_rst_err", bus.protoErr, 0);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
